// File: rtl/commit_trace_fifo.sv
// Commit trace FIFO: captures GRF writes (W stage) and stores (M stage) from the mips core
// and streams them, oldest first, with a cycle stamp over a valid/ready port.
module commit_trace_fifo #(
    parameter int DEPTH     = 16,
    parameter bit DROP_ZERO = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        trace_en,
    input  logic        w_grf_we,
    input  logic [4:0]  w_grf_addr,
    input  logic [31:0] w_grf_wdata,
    input  logic [31:0] w_inst_addr,
    input  logic [3:0]  m_data_byteen,
    input  logic [31:0] m_data_addr,
    input  logic [31:0] m_data_wdata,
    input  logic [31:0] m_data_rdata,
    input  logic [31:0] m_inst_addr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_kind,
    output logic [31:0] out_pc,
    output logic [31:0] out_addr,
    output logic [31:0] out_data,
    output logic [31:0] out_cycle,
    output logic [15:0] drop_cnt,
    output logic        overflow
);

    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic        kind;
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] cycle;
    } entry_t;

    entry_t      mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr_plus1;
    logic [AW:0]   count;
    logic [AW:0]   free_slots;
    logic [31:0]   cycle_cnt;

    logic        grf_ev;
    logic        mem_ev;
    logic        push_a;
    logic        push_b;
    logic        pop;
    logic [1:0]  n_events;
    logic [1:0]  n_push;
    logic [1:0]  n_drop;
    logic [16:0] drop_sum;
    logic [31:0] merged;
    entry_t      grf_entry;
    entry_t      mem_entry;
    entry_t      entry_a;
    entry_t      head;

    assign grf_ev = trace_en & w_grf_we & !(DROP_ZERO && (w_grf_addr == 5'd0));
    assign mem_ev = trace_en & (|m_data_byteen);

    always_comb begin
        merged = m_data_rdata;
        for (int i = 0; i < 4; i++) begin
            if (m_data_byteen[i]) merged[8*i +: 8] = m_data_wdata[8*i +: 8];
        end
    end

    assign grf_entry = '{kind: 1'b0, pc: w_inst_addr, addr: {27'd0, w_grf_addr},
                         data: w_grf_wdata, cycle: cycle_cnt};
    assign mem_entry = '{kind: 1'b1, pc: m_inst_addr, addr: {m_data_addr[31:2], 2'b00},
                         data: merged, cycle: cycle_cnt};
    assign entry_a   = grf_ev ? grf_entry : mem_entry;

    // Free space is judged on the pre-pop count, so a slot vacated this cycle is not reused.
    assign free_slots   = (AW+1)'(DEPTH) - count;
    assign push_a       = (grf_ev | mem_ev) && (free_slots != '0);
    assign push_b       = grf_ev && mem_ev && (free_slots >= (AW+1)'(2));
    assign n_events     = {1'b0, grf_ev} + {1'b0, mem_ev};
    assign n_push       = {1'b0, push_a} + {1'b0, push_b};
    assign n_drop       = n_events - n_push;
    assign drop_sum     = {1'b0, drop_cnt} + {15'd0, n_drop};
    assign wr_ptr_plus1 = wr_ptr + AW'(1);

    assign out_valid = (count != '0);
    assign pop       = out_valid & out_ready;
    assign head      = out_valid ? mem[rd_ptr] : '0;
    assign out_kind  = head.kind;
    assign out_pc    = head.pc;
    assign out_addr  = head.addr;
    assign out_data  = head.data;
    assign out_cycle = head.cycle;

    always_ff @(posedge clk) begin
        if (push_a) mem[wr_ptr] <= entry_a;
        if (push_b) mem[wr_ptr_plus1] <= mem_entry;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            cycle_cnt <= '0;
            drop_cnt  <= '0;
            overflow  <= 1'b0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            wr_ptr    <= wr_ptr + AW'(n_push);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count     <= count + (AW+1)'(n_push) - (AW+1)'(pop);
            drop_cnt  <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            if (n_drop != 2'd0) overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_commit_trace_fifo.sv
// Directed bench for commit_trace_fifo: table of single-event vectors plus
// hand-written sequences for dual push, overflow/drop, and mid-stream reset.
module tb_commit_trace_fifo;

    logic        clk = 1'b0;
    logic        reset;
    logic        trace_en;
    logic        w_grf_we;
    logic [4:0]  w_grf_addr;
    logic [31:0] w_grf_wdata;
    logic [31:0] w_inst_addr;
    logic [3:0]  m_data_byteen;
    logic [31:0] m_data_addr;
    logic [31:0] m_data_wdata;
    logic [31:0] m_data_rdata;
    logic [31:0] m_inst_addr;
    logic        out_valid;
    logic        out_ready;
    logic        out_kind;
    logic [31:0] out_pc;
    logic [31:0] out_addr;
    logic [31:0] out_data;
    logic [31:0] out_cycle;
    logic [15:0] drop_cnt;
    logic        overflow;

    int compared   = 0;
    int mismatched = 0;
    int edge_cnt;

    always #5 clk = ~clk;

    commit_trace_fifo #(.DEPTH(16), .DROP_ZERO(1'b1)) dut (
        .clk(clk), .reset(reset), .trace_en(trace_en),
        .w_grf_we(w_grf_we), .w_grf_addr(w_grf_addr), .w_grf_wdata(w_grf_wdata),
        .w_inst_addr(w_inst_addr), .m_data_byteen(m_data_byteen), .m_data_addr(m_data_addr),
        .m_data_wdata(m_data_wdata), .m_data_rdata(m_data_rdata), .m_inst_addr(m_inst_addr),
        .out_valid(out_valid), .out_ready(out_ready), .out_kind(out_kind), .out_pc(out_pc),
        .out_addr(out_addr), .out_data(out_data), .out_cycle(out_cycle),
        .drop_cnt(drop_cnt), .overflow(overflow)
    );

    // Reference cycle counter: posedges seen since reset was released.
    always @(posedge clk or negedge reset) begin
        if (!reset) edge_cnt <= 0;
        else        edge_cnt <= edge_cnt + 1;
    end

    typedef struct {
        logic        en;
        logic        we;
        logic [4:0]  ga;
        logic [31:0] gd;
        logic [31:0] gpc;
        logic [3:0]  be;
        logic [31:0] ma;
        logic [31:0] md;
        logic [31:0] mr;
        logic [31:0] mpc;
        logic        exp_valid;
        logic        exp_kind;
        logic [31:0] exp_pc;
        logic [31:0] exp_addr;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs [8];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic checkHead(input string tag, input logic v, input logic k,
                             input logic [31:0] pc, input logic [31:0] addr,
                             input logic [31:0] data, input logic [31:0] cyc);
        checkOutput({tag, ".valid"}, {31'd0, out_valid}, {31'd0, v});
        checkOutput({tag, ".kind"},  {31'd0, out_kind},  {31'd0, k});
        checkOutput({tag, ".pc"},    out_pc,    pc);
        checkOutput({tag, ".addr"},  out_addr,  addr);
        checkOutput({tag, ".data"},  out_data,  data);
        checkOutput({tag, ".cycle"}, out_cycle, cyc);
    endtask

    task automatic idle();
        trace_en      = 1'b1;
        w_grf_we      = 1'b0;
        w_grf_addr    = 5'd0;
        w_grf_wdata   = 32'd0;
        w_inst_addr   = 32'd0;
        m_data_byteen = 4'd0;
        m_data_addr   = 32'd0;
        m_data_wdata  = 32'd0;
        m_data_rdata  = 32'd0;
        m_inst_addr   = 32'd0;
    endtask

    task automatic applyStimulus(input vec_t v);
        trace_en      = v.en;
        w_grf_we      = v.we;
        w_grf_addr    = v.ga;
        w_grf_wdata   = v.gd;
        w_inst_addr   = v.gpc;
        m_data_byteen = v.be;
        m_data_addr   = v.ma;
        m_data_wdata  = v.md;
        m_data_rdata  = v.mr;
        m_inst_addr   = v.mpc;
    endtask

    task automatic driveGrf(input logic [4:0] r, input logic [31:0] d, input logic [31:0] pc);
        w_grf_we    = 1'b1;
        w_grf_addr  = r;
        w_grf_wdata = d;
        w_inst_addr = pc;
    endtask

    task automatic driveStore(input logic [3:0] be, input logic [31:0] a, input logic [31:0] d,
                              input logic [31:0] rd, input logic [31:0] pc);
        m_data_byteen = be;
        m_data_addr   = a;
        m_data_wdata  = d;
        m_data_rdata  = rd;
        m_inst_addr   = pc;
    endtask

    initial begin
        int cyc;
        //             en   we   ga     gd            gpc           be       ma            md            mr            mpc           v     k     pc            addr          data
        vecs[0] = '{1'b1, 1'b1, 5'd3,  32'h12345678, 32'h00003004, 4'b0000, 32'h0,        32'h0,        32'h0,        32'h0,        1'b1, 1'b0, 32'h00003004, 32'h00000003, 32'h12345678};
        vecs[1] = '{1'b1, 1'b0, 5'd0,  32'h0,        32'h0,        4'b0100, 32'h00000006, 32'h00AB0000, 32'h11223344, 32'h00003008, 1'b1, 1'b1, 32'h00003008, 32'h00000004, 32'h11AB3344};
        vecs[2] = '{1'b1, 1'b0, 5'd0,  32'h0,        32'h0,        4'b1111, 32'h00001003, 32'hDEADBEEF, 32'h00000000, 32'h0000300C, 1'b1, 1'b1, 32'h0000300C, 32'h00001000, 32'hDEADBEEF};
        vecs[3] = '{1'b1, 1'b0, 5'd0,  32'h0,        32'h0,        4'b0011, 32'h00002000, 32'h0000CAFE, 32'hAABBCCDD, 32'h00003010, 1'b1, 1'b1, 32'h00003010, 32'h00002000, 32'hAABBCAFE};
        vecs[4] = '{1'b1, 1'b0, 5'd0,  32'h0,        32'h0,        4'b1001, 32'h0000000A, 32'h11000022, 32'h33445566, 32'h00003014, 1'b1, 1'b1, 32'h00003014, 32'h00000008, 32'h11445522};
        vecs[5] = '{1'b1, 1'b1, 5'd0,  32'hFFFFFFFF, 32'h00003018, 4'b0000, 32'h0,        32'h0,        32'h0,        32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        32'h0};
        vecs[6] = '{1'b1, 1'b1, 5'd31, 32'hFFFFFFFF, 32'h00004000, 4'b0000, 32'h0,        32'h0,        32'h0,        32'h0,        1'b1, 1'b0, 32'h00004000, 32'h0000001F, 32'hFFFFFFFF};
        vecs[7] = '{1'b0, 1'b1, 5'd4,  32'h44444444, 32'h00004004, 4'b1111, 32'h00000100, 32'h1,        32'h2,        32'h00004008, 1'b0, 1'b0, 32'h0,        32'h0,        32'h0};

        reset     = 1'b0;
        out_ready = 1'b0;
        idle();
        #12;
        checkHead("reset", 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        checkOutput("reset.drop_cnt", {16'd0, drop_cnt}, 32'd0);
        checkOutput("reset.overflow", {31'd0, overflow}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            out_ready = 1'b1;
            cyc = edge_cnt;
            @(negedge clk);
            checkHead($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_kind,
                      vecs[i].exp_pc, vecs[i].exp_addr, vecs[i].exp_data,
                      vecs[i].exp_valid ? 32'(cyc) : 32'h0);
            checkOutput($sformatf("vec%0d.drop_cnt", i), {16'd0, drop_cnt}, 32'd0);
            idle();
            @(negedge clk);
            checkOutput($sformatf("vec%0d.drained", i), {31'd0, out_valid}, 32'd0);
        end

        // Same-cycle GRF write and store: GRF entry first, both carrying the same stamp.
        @(negedge clk);
        out_ready = 1'b0;
        driveGrf(5'd5, 32'h55555555, 32'h00005000);
        driveStore(4'b1111, 32'h00000040, 32'h0BADF00D, 32'h0, 32'h00004FFC);
        cyc = edge_cnt;
        @(negedge clk);
        idle();
        checkHead("dual.first", 1'b1, 1'b0, 32'h00005000, 32'h5, 32'h55555555, 32'(cyc));
        out_ready = 1'b1;
        @(negedge clk);
        checkHead("dual.second", 1'b1, 1'b1, 32'h00004FFC, 32'h40, 32'h0BADF00D, 32'(cyc));
        @(negedge clk);
        checkOutput("dual.drained", {31'd0, out_valid}, 32'd0);

        // Fill to one free slot, then overflow in several ways.
        out_ready = 1'b0;
        for (int r = 1; r <= 15; r++) begin
            driveGrf(5'(r), 32'(r), 32'h00006000 + 32'(4 * r));
            @(negedge clk);
        end
        checkOutput("fill.drop_cnt", {16'd0, drop_cnt}, 32'd0);
        driveGrf(5'd16, 32'd16, 32'h00006040);
        driveStore(4'b0001, 32'h0, 32'hFF, 32'h0, 32'h0000603C);
        @(negedge clk);
        checkOutput("full.drop_cnt", {16'd0, drop_cnt}, 32'd1);
        checkOutput("full.overflow", {31'd0, overflow}, 32'd1);
        checkHead("full.head", 1'b1, 1'b0, 32'h00006004, 32'h1, 32'h1, out_cycle);
        idle();
        driveGrf(5'd20, 32'd20, 32'h00007000);
        @(negedge clk);
        checkOutput("full.drop2", {16'd0, drop_cnt}, 32'd2);
        driveStore(4'b0010, 32'h0, 32'h0, 32'h0, 32'h00007004);
        @(negedge clk);
        checkOutput("full.drop4", {16'd0, drop_cnt}, 32'd4);
        idle();
        driveGrf(5'd21, 32'd21, 32'h00007008);
        out_ready = 1'b1;
        @(negedge clk);
        idle();
        checkOutput("popfull.drop5", {16'd0, drop_cnt}, 32'd5);
        checkOutput("popfull.head", out_addr, 32'd2);
        for (int r = 3; r <= 16; r++) begin
            @(negedge clk);
            checkOutput($sformatf("drain%0d.addr", r), out_addr, 32'(r));
            checkOutput($sformatf("drain%0d.data", r), out_data, 32'(r));
        end
        @(negedge clk);
        checkOutput("drain.empty", {31'd0, out_valid}, 32'd0);
        checkOutput("drain.overflow", {31'd0, overflow}, 32'd1);

        // Queue five entries, then reset mid-cycle.
        out_ready = 1'b0;
        for (int r = 1; r <= 5; r++) begin
            driveGrf(5'(r), 32'hA0 + 32'(r), 32'h00008000);
            @(negedge clk);
        end
        idle();
        checkOutput("queued.valid", {31'd0, out_valid}, 32'd1);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        checkOutput("midrst.valid", {31'd0, out_valid}, 32'd0);
        checkOutput("midrst.pc", out_pc, 32'd0);
        checkOutput("midrst.drop_cnt", {16'd0, drop_cnt}, 32'd0);
        checkOutput("midrst.overflow", {31'd0, overflow}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        out_ready = 1'b1;
        driveGrf(5'd7, 32'h00000077, 32'h00009000);
        @(negedge clk);
        idle();
        checkHead("postrst", 1'b1, 1'b0, 32'h00009000, 32'h7, 32'h77, 32'h0);
        @(negedge clk);
        checkOutput("postrst.drained", {31'd0, out_valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
